// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment read-side path: glyph patterns
// as they appear on the active-low gfedcba bus, the 4-bit codes recovered
// from them, and the scan FSM state type.
package sseg_pkg;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Codes that are not plain hexadecimal digit values
    localparam logic [3:0] CODE_A     = 4'hA;
    localparam logic [3:0] CODE_L     = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hC;
    localparam logic [3:0] CODE_ERR   = 4'hE;
    localparam logic [3:0] CODE_DASH  = 4'hF;

    // Scan FSM: wait for a select, let it settle, sample once, wait for the next digit
    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_DWELL   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } scan_state_t;

    // True when a segment pattern shows no lit segment at all
    function automatic logic is_blank(input logic [6:0] seg);
        return seg == SEG_BLANK;
    endfunction

endpackage

// File: rtl/sseg2code.sv
// Combinational decoder from an active-low seven-segment pattern back to the
// 4-bit code that produced it. Patterns outside the glyph set map to the
// error code with err raised.
module sseg2code
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    // Table lookup; everything not in the glyph set is reported as an error
    always_comb begin
        code = CODE_ERR;
        err  = 1'b0;
        if (is_blank(seg)) begin
            code = CODE_BLANK;
        end else begin
            case (seg)
                SEG_0:    code = 4'h0;
                SEG_1:    code = 4'h1;
                SEG_2:    code = 4'h2;
                SEG_3:    code = 4'h3;
                SEG_4:    code = 4'h4;
                SEG_5:    code = 4'h5;
                SEG_6:    code = 4'h6;
                SEG_7:    code = 4'h7;
                SEG_8:    code = 4'h8;
                SEG_9:    code = 4'h9;
                SEG_A:    code = CODE_A;
                SEG_L:    code = CODE_L;
                SEG_DASH: code = CODE_DASH;
                default: begin
                    code = CODE_ERR;
                    err  = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/sseg_scan_reader.sv
// Read-side capture of a multiplexed active-low seven-segment bus. Each digit
// is sampled once after its select/segment pair has settled, whole frames are
// compared against the previous frame, and only a frame seen STABLE_FRAMES
// times in a row is published on BCD/digit_err with a one-cycle valid pulse.
module sseg_scan_reader
    import sseg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int MIN_DWELL     = 16,
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT       = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            Sseg,
    input  logic [DIGITS-1:0]     An,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  valid,
    output logic                  stale
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(MIN_DWELL) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int MW = $clog2(STABLE_FRAMES) + 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(MIN_DWELL - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [MW-1:0] MATCH_TOP  = MW'(STABLE_FRAMES - 1);

    // Synchronizer stages plus one extra stage used as the change reference
    logic [6:0]        seg_s1, seg_s2, seg_q;
    logic [DIGITS-1:0] an_s1,  an_s2,  an_q;

    // FSM and counters
    scan_state_t       state, state_next;
    logic [DW-1:0]     dwell_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic [DIGITS-1:0] hold_an;

    // Frame storage
    logic [DIGITS-1:0][3:0] buf_code, prev_code;
    logic [DIGITS-1:0]      buf_err,  prev_err;
    logic [DIGITS-1:0]      cap_mask;
    logic [MW-1:0]          match_cnt, match_next;

    // Combinational helpers
    logic              sel_legal;
    logic              bus_changed;
    logic [IW-1:0]     sel_idx;
    logic [3:0]        cap_code;
    logic              cap_err;
    logic              capture_en;
    logic              timeout_hit;
    logic              frame_done;
    logic              frame_eq;
    logic              publish;
    logic [4*DIGITS-1:0] buf_flat;

    assign buf_flat = buf_code;

    // Two-flop synchronizer on the asynchronous bus, idle (all high) after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            seg_q  <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
            an_q   <= '1;
        end else begin
            seg_s1 <= Sseg;
            seg_s2 <= seg_s1;
            seg_q  <= seg_s2;
            an_s1  <= An;
            an_s2  <= an_s1;
            an_q   <= an_s2;
        end
    end

    // Legal select means exactly one digit line pulled low
    always_comb begin
        sel_legal   = ($countones(~an_s2) == 1);
        bus_changed = (an_s2 != an_q) || (seg_s2 != seg_q);
    end

    // Index of the digit being captured, taken from the last settled select
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    // The settled pattern from the final dwell cycle is what gets decoded
    sseg2code u_decode (
        .seg  (seg_q),
        .code (cap_code),
        .err  (cap_err)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SCAN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: settle, sample once, then wait for the select to move on
    always_comb begin
        state_next = state;
        case (state)
            ST_SCAN: begin
                if (sel_legal) begin
                    state_next = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (!sel_legal) begin
                    state_next = ST_SCAN;
                end else if (!bus_changed && dwell_cnt == DWELL_LAST) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (an_s2 != hold_an) begin
                    state_next = sel_legal ? ST_DWELL : ST_SCAN;
                end
            end
            default: state_next = ST_SCAN;
        endcase
    end

    // FSM outputs
    always_comb begin
        capture_en = (state == ST_CAPTURE);
    end

    // Dwell counter restarts on any bus movement and only runs while dwelling
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
        end else if (state != ST_DWELL || bus_changed) begin
            dwell_cnt <= '0;
        end else if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    // Remember the captured select so HOLD notices a change even during CAPTURE
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_an <= '1;
        end else if (capture_en) begin
            hold_an <= an_q;
        end
    end

    // Timeout counter cleared by every capture, parks at its last value
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (capture_en) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Frame comparison and publish decision, evaluated the cycle the mask fills
    always_comb begin
        timeout_hit = (tmo_cnt == TMO_LAST) && !capture_en;
        frame_done  = (cap_mask == '1);
        frame_eq    = (buf_code == prev_code) && (buf_err == prev_err);
        match_next  = '0;
        if (frame_eq) begin
            match_next = (match_cnt == MATCH_TOP) ? MATCH_TOP : match_cnt + MW'(1);
        end
        publish = frame_done && !timeout_hit && !capture_en
                  && (match_next == MATCH_TOP)
                  && ((buf_flat != BCD) || (buf_err != digit_err) || stale);
    end

    // Frame buffer, capture mask, match counter and previous-frame register
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_code  <= '0;
            buf_err   <= '0;
            cap_mask  <= '0;
            prev_code <= '0;
            prev_err  <= '0;
            match_cnt <= '0;
        end else if (capture_en) begin
            buf_code[sel_idx] <= cap_code;
            buf_err[sel_idx]  <= cap_err;
            cap_mask[sel_idx] <= 1'b1;
        end else if (timeout_hit) begin
            cap_mask  <= '0;
            match_cnt <= '0;
            prev_code <= '0;
            prev_err  <= '0;
        end else if (frame_done) begin
            cap_mask  <= '0;
            match_cnt <= match_next;
            if (!frame_eq) begin
                prev_code <= buf_code;
                prev_err  <= buf_err;
            end
        end
    end

    // Published outputs: update on publish, go stale on timeout, BCD held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            BCD       <= '0;
            digit_err <= '0;
            valid     <= 1'b0;
            stale     <= 1'b1;
        end else begin
            valid <= publish;
            if (publish) begin
                BCD       <= buf_flat;
                digit_err <= buf_err;
                stale     <= 1'b0;
            end else if (timeout_hit) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sseg_scan_reader.md
# sseg_scan_reader

Captures a time-multiplexed, active-low seven-segment display bus (segment lines plus digit-select lines) and recovers the 4-bit code shown on each digit. It is the read-side counterpart of the BCD-to-segment encoding used by the display path. Typical uses are self-check of the display driver and capture of front-panel output in the board test harness. It accepts only settled digits, checks each scan frame for stability, and publishes a registered multi-digit code word with per-digit error flags.

## Interface
- DIGITS, 4: number of multiplexed digits, 1..8
- MIN_DWELL, 16: cycles a select/segment pair must hold unchanged before it is sampled, ≥2
- STABLE_FRAMES, 2: consecutive identical complete frames required before publishing, ≥1
- TIMEOUT, 65536: cycles without any capture before the output is marked stale
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- Sseg  in  7  segment lines gfedcba, active-low (bit 6 = g); asynchronous
- An  in  DIGITS  digit selects, active-low; asynchronous
- BCD  out  4*DIGITS  published codes; digit i in bits [4i+3:4i]
- digit_err  out  DIGITS  1 = digit i showed an undecodable pattern in the published frame
- valid  out  1  one-cycle pulse when BCD/digit_err are updated
- stale  out  1  1 = no valid capture for TIMEOUT cycles, or nothing published since reset

## Operation
- Sseg and An pass through a 2-flop synchronizer. All later logic uses the synchronized values.
- Select is legal only when exactly one An bit is 0. All-high or multi-low selects are idle: the dwell counter clears and nothing is captured.
- Decode table (pattern -> code):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9
  - 0001000->A, 1000111->B ('L'), 0111111->F (dash), 1111111->C (blank)
  - Anything else -> E, with the error bit set for that digit.
- FSM states:
  - SCAN: waiting for a legal select. Goes to DWELL on a legal select.
  - DWELL: counting. Any change of the synchronized An or Sseg restarts the count. On an illegal select, returns to SCAN. When the count reaches MIN_DWELL-1, goes to CAPTURE.
  - CAPTURE: one cycle. Writes code and error bit into the frame buffer slot for the selected digit and sets that bit of the capture mask. Goes to HOLD.
  - HOLD: ignores the bus until An changes, so only one capture happens per dwell. On the change, goes to DWELL if the new select is legal, else to SCAN.
- Frame complete: the capture mask is all ones. A repeated capture of the same digit within a frame overwrites the slot.
- On frame complete:
  - Compare the frame buffer with the previous-frame register.
  - If equal, increment the match counter, saturating. Otherwise load the match counter with 0 and copy the frame into the previous-frame register.
  - Clear the capture mask.
- Publish when the match count reaches STABLE_FRAMES-1 and either the frame differs from BCD/digit_err or stale=1. Publishing loads BCD and digit_err, pulses valid, and clears stale. An identical frame is not re-published.
- With STABLE_FRAMES=1, every complete frame that differs from the published one is published immediately.
- Timeout counter: cleared on every CAPTURE. When it reaches TIMEOUT-1: stale<=1, capture mask, match counter and previous-frame register cleared, BCD held.

## Timing
- Reset values:
  - BCD=0, digit_err=0, valid=0, stale=1
  - FSM=SCAN; mask, match count, timeouts and buffers all 0
- Latency from a bus value settling at the pins to its slot write: 2 sync cycles + MIN_DWELL cycles + 1 capture cycle.
- Last capture of the qualifying frame (cycle t): comparison and mask clear at t+1, valid and new BCD at t+2.
- Capture and timeout in the same cycle: the capture wins and the timeout counter clears.
- Reset mid-frame discards all partial state; the first publication after reset requires STABLE_FRAMES full frames.

## Structure
- Shared package sseg_pkg:
  - segment pattern constants for all 14 glyphs
  - code constants CODE_L=4'hB, CODE_BLANK=4'hC, CODE_ERR=4'hE, CODE_DASH=4'hF
  - FSM state enum
- Sub-module sseg2code: purely combinational. Input 7-bit pattern; outputs 4-bit code and err. Shared with any future display checker.
- Top module holds the synchronizer, FSM, dwell/timeout counters, frame buffer, previous-frame register and publish logic.

## Test plan
- Reset, then scan digits 0..3 with patterns "1","2","3","4", each held 40 cycles, for 2 frames -> one valid pulse; BCD=16'h4321, digit_err=0, stale 1->0.
- Keep scanning the same frames for 5 more frames -> no further valid pulses.
- Digit 2 held only 10 cycles (less than MIN_DWELL) in every frame -> no frame completes; no valid, BCD unchanged.
- Digit 1 shows 0101010 for two frames -> BCD nibble 1 = E, digit_err=4'b0010, valid pulses once.
- Hold An=4'b1111 for TIMEOUT cycles after a publication -> stale=1, BCD held. Resume the scan -> republish after 2 frames, stale=0.
- Assert rst midway through the second frame -> all outputs return to reset values; publication needs 2 new full frames.
